// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, one-hot controls, FSM states.
package alu_seq_pkg;

   localparam int OP_W   = 4;
   localparam int CTRL_W = 13;
   localparam int CNT_W  = 4;

   localparam logic [OP_W-1:0] OP_AND  = 4'd0;
   localparam logic [OP_W-1:0] OP_OR   = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd4;
   localparam logic [OP_W-1:0] OP_DIV  = 4'd5;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
   localparam logic [OP_W-1:0] OP_SHRA = 4'd7;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
   localparam logic [OP_W-1:0] OP_ROR  = 4'd9;
   localparam logic [OP_W-1:0] OP_ROL  = 4'd10;
   localparam logic [OP_W-1:0] OP_NEG  = 4'd11;
   localparam logic [OP_W-1:0] OP_NOT  = 4'd12;
   localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd13;

   localparam logic [CTRL_W-1:0] CTRL_NONE = 13'h0000;
   localparam logic [CTRL_W-1:0] CTRL_AND  = 13'h0001;
   localparam logic [CTRL_W-1:0] CTRL_OR   = 13'h0002;
   localparam logic [CTRL_W-1:0] CTRL_ADD  = 13'h0004;
   localparam logic [CTRL_W-1:0] CTRL_SUB  = 13'h0008;
   localparam logic [CTRL_W-1:0] CTRL_MUL  = 13'h0010;
   localparam logic [CTRL_W-1:0] CTRL_DIV  = 13'h0020;
   localparam logic [CTRL_W-1:0] CTRL_SHR  = 13'h0040;
   localparam logic [CTRL_W-1:0] CTRL_SHRA = 13'h0080;
   localparam logic [CTRL_W-1:0] CTRL_SHL  = 13'h0100;
   localparam logic [CTRL_W-1:0] CTRL_ROR  = 13'h0200;
   localparam logic [CTRL_W-1:0] CTRL_ROL  = 13'h0400;
   localparam logic [CTRL_W-1:0] CTRL_NEG  = 13'h0800;
   localparam logic [CTRL_W-1:0] CTRL_NOT  = 13'h1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: one-hot ALU control, hold count (latency-1), illegal flag.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic [OP_W-1:0]   op,
   output logic [CTRL_W-1:0] ctrl,
   output logic [CNT_W-1:0]  lat_m1,
   output logic              illegal
);

   always_comb begin
      ctrl    = CTRL_NONE;
      lat_m1  = '0;
      illegal = 1'b0;
      case (op)
         OP_AND:  ctrl = CTRL_AND;
         OP_OR:   ctrl = CTRL_OR;
         OP_ADD:  ctrl = CTRL_ADD;
         OP_SUB:  ctrl = CTRL_SUB;
         OP_MUL: begin
            ctrl   = CTRL_MUL;
            lat_m1 = CNT_W'(MUL_CYCLES - 1);
         end
         OP_DIV: begin
            ctrl   = CTRL_DIV;
            lat_m1 = CNT_W'(DIV_CYCLES - 1);
         end
         OP_SHR:  ctrl = CTRL_SHR;
         OP_SHRA: ctrl = CTRL_SHRA;
         OP_SHL:  ctrl = CTRL_SHL;
         OP_ROR:  ctrl = CTRL_ROR;
         OP_ROL:  ctrl = CTRL_ROL;
         OP_NEG:  ctrl = CTRL_NEG;
         OP_NOT:  ctrl = CTRL_NOT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: holds one-hot control per op latency, captures Z, pulses done.
// Define ALU_SEQ_DIV0_CHECK_EN to reject DIV by zero as an illegal op.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// EXEC    | alu_control driven, counter runs down to zero
// DONE    | done pulse, Z and err valid
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [31:0]       req_a,
   input  logic [31:0]       req_b,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [63:0]       alu_c,
   output logic [31:0]       z_hi,
   output logic [31:0]       z_lo,
   output logic              done,
   output logic              busy,
   output logic              err
);

   seq_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [CTRL_W-1:0]  dec_ctrl;
   logic [CNT_W-1:0]   dec_lat_m1;
   logic               dec_illegal;
   logic               reject;

   alu_op_decode #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_decode (
      .op      (req_op),
      .ctrl    (dec_ctrl),
      .lat_m1  (dec_lat_m1),
      .illegal (dec_illegal)
   );

`ifdef ALU_SEQ_DIV0_CHECK_EN
   assign reject = dec_illegal || ((req_op == OP_DIV) && (req_b == '0));
`else
   assign reject = dec_illegal;
`endif

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= CTRL_NONE;
         z_hi        <= '0;
         z_lo        <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
         req_ready   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  alu_a     <= req_a;
                  alu_b     <= req_b;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  // rejected ops skip EXEC so the ALU is never strobed
                  if (reject) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     err         <= 1'b0;
                     cnt         <= dec_lat_m1;
                     alu_control <= dec_ctrl;
                     state       <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  z_hi        <= alu_c[63:32];
                  z_lo        <= alu_c[31:0];
                  alu_control <= CTRL_NONE;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state       <= ST_IDLE;
               alu_control <= CTRL_NONE;
               done        <= 1'b0;
               busy        <= 1'b0;
               req_ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer for the 32-bit ALU datapath. Accepts one encoded ALU operation at a time over a valid/ready handshake, registers the operands, and drives the ALU's 13-bit one-hot control for a per-operation number of cycles. Multiply and divide get extra cycles so their long combinational paths settle. It then captures the 64-bit result into the Z register pair and pulses `done`. It sits between the control unit and the ALU, replacing direct one-hot control drive.

## Interface
- `MUL_CYCLES`, default 4: cycles the control is held for MUL, range 1–15.
- `DIV_CYCLES`, default 8: cycles the control is held for DIV, range 1–15.
- `clock` input 1: single clock; all state changes on the rising edge.
- `clear_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: operation request.
- `req_ready` output 1: sequencer can accept; high only in IDLE.
- `req_op` input 4: op code 0..12 = AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT. Codes 13..15 are illegal.
- `req_a`, `req_b` input 32 each: operands, sampled on handshake.
- `alu_a`, `alu_b` output 32 each: registered operands to the ALU.
- `alu_control` output 13: one-hot ALU control; bit n corresponds to op n. All-zero when not executing.
- `alu_c` input 64: ALU result.
- `z_hi`, `z_lo` output 32 each: captured result, `alu_c[63:32]` and `alu_c[31:0]`.
- `done` output 1: one-cycle pulse; Z and `err` are valid.
- `busy` output 1: high in any state other than IDLE.
- `err` output 1: set with `done` for an illegal op (or div-by-zero, see Configuration). Held until the next accept.

## Operation
- States are IDLE, EXEC and DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` at an edge: latch `req_a`/`req_b` into `alu_a`/`alu_b`, latch the op, clear `err`.
  - Load the counter with latency−1: 0 for single-cycle ops, `MUL_CYCLES`−1 for MUL, `DIV_CYCLES`−1 for DIV.
  - Go to EXEC.
- **EXEC**
  - `alu_control` = decoded one-hot, driven from registered state, glitch-free.
  - While counter≠0: decrement.
  - At an edge with counter==0: Z ← `alu_c`, go to DONE.
- **DONE**
  - `done`=1 and `alu_control`=0 for one cycle.
  - Return to IDLE.
  - A new request is accepted no earlier than the following IDLE cycle.
- **Illegal op** (13..15):
  - Go from IDLE directly to DONE with `err`=1.
  - `alu_control` is never asserted; Z is unchanged.
- **Width rules**
  - Z always captures all 64 bits.
  - ADD: carry appears in `z_hi[0]`.
  - 32-bit ops: `z_hi` is whatever the ALU drives, not masked here.
  - DIV: `z_hi` = remainder, `z_lo` = quotient.
- **Stability:** `alu_a`/`alu_b` are held constant from accept until the next accept.
- **Request changes:** `req_*` changes while `busy` are ignored.

## Timing
- **Reset values:** state IDLE, `alu_a`/`alu_b`/`z_hi`/`z_lo` = 0, `alu_control` = 0, `done` = 0, `err` = 0, `busy` = 0, `req_ready` = 1.
- **Latency:** accept at edge T; `done` is high in cycle T+1+L, where L = 1 for single-cycle ops, `MUL_CYCLES` for MUL, `DIV_CYCLES` for DIV.
  - Example: ADD accepted at edge 0 gives `done` in cycle 2.
- **Illegal op:** `done` in cycle T+1.
- **Throughput:** one op per L+2 cycles.
- **Reset mid-operation:** `clear_n` low asynchronously forces all reset values. An in-flight op is discarded with no `done`, and Z is cleared.
- **Valid held across DONE:** `req_valid` held high through DONE is accepted in the following IDLE cycle only.

## Configuration
- `ALU_SEQ_DIV0_CHECK_EN` defined:
  - DIV with `req_b`==0 behaves as an illegal op: direct to DONE, `err`=1, Z unchanged, ALU never strobed.
- Undefined:
  - DIV by zero executes normally for `DIV_CYCLES`.
  - Z captures whatever the ALU produces; `err`=0.

## Structure
- **Package `alu_seq_pkg`:**
  - op code constants OP_AND..OP_NOT
  - state enum
  - 13-bit one-hot control constants
  - `OP_ILLEGAL_MIN`=13
- **Sub-module `alu_op_decode`:** combinational op → {one-hot control, latency, illegal flag}. It is instantiated once; the FSM, counter and registers stay in `alu_sequencer`.

## Test plan
- **Reset, then ADD:** reset; ADD A=32'hFFFFFFFF, B=1 → `done` in cycle 2; `z_lo`=0, `z_hi`=1; `alu_control`=13'h0004 only during EXEC.
- **MUL latency:** MUL A=32'h0001_0000, B=32'h0001_0000 with `MUL_CYCLES`=4 → `alu_control`=13'h0010 for exactly 4 cycles; `done` in cycle 5; {`z_hi`,`z_lo`}=64'h1_0000_0000.
- **DIV:** DIV A=17, B=5 → `z_lo`=3, `z_hi`=2, `done` at cycle `DIV_CYCLES`+1.
- **Illegal op:** `req_op`=14 → `done`+`err` in cycle 1; `alu_control` never nonzero; Z unchanged.
- **Divide by zero:** DIV B=0 → with `ALU_SEQ_DIV0_CHECK_EN`: `err`=1, `done` in cycle 1. Without it: `err`=0, `done` at `DIV_CYCLES`+1.
- **Reset mid-operation and back-to-back:** assert `clear_n` low during MUL EXEC → all outputs zero immediately, no `done`. Then back-to-back SUB 5−7 and NOT 0 with `req_valid` held → `z_lo`=32'hFFFFFFFE, then 32'hFFFFFFFF; second accept exactly one cycle after the first `done`.
